// File: rtl/muldiv_iter.sv
// muldiv_iter -- shared iterative multiply/divide unit for the EX stage.
//
// One radix-2 datapath serves MULT/MULTU, DIV/DIVU and the accumulate ops
// MADD/MADDU/MSUB/MSUBU (HI:LO +/- product). Operands are converted to
// magnitudes at accept; signs are re-applied in the FIX state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   request; op/operands sampled when in_valid && in_ready
//   in_ready   unit idle and able to accept
//   op[2:0]    000 MULT 001 MULTU 010 DIV 011 DIVU 100 MADD 101 MADDU 110 MSUB 111 MSUBU
//   srca       multiplicand / dividend
//   srcb       multiplier / divisor
//   hi_in      current HI (accumulate ops)
//   lo_in      current LO (accumulate ops)
//   cancel     pipeline flush; aborts any in-flight op
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes result
//   hi, lo     mul: product high/low half; div: remainder / quotient
//   div_zero   divisor was zero (qualifies out_valid)
//
// Build option: define MULDIV_EARLY_EXIT_EN to let multiplies leave CALC as
// soon as the remaining multiplier bits are zero (division is unaffected).
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [2:0]         op_q;
  logic               sa_q, sb_q;
  logic [2*WIDTH-1:0] acc_q;    // mul: running product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand_q;  // multiplicand, shifted left each step
  logic [2*WIDTH-1:0] base_q;   // accumulate ops: {hi_in,lo_in}; div: raw dividend
  logic [WIDTH-1:0]   b_q;      // mul: multiplier, shifted right; div: divisor magnitude

  logic               accept, in_sgn, in_div, is_div_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod, sum;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_dz;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? ('0 - x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? ('0 - x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? ('0 - x) : x;
  endfunction

  assign accept   = (state_q == IDLE) && in_valid && !cancel;
  assign in_sgn   = ~op[0];
  assign in_div   = ~op[2] & op[1];
  assign is_div_q = ~op_q[2] & op_q[1];
  assign a_mag    = mag(srca, in_sgn);
  assign b_mag    = mag(srcb, in_sgn);

  // One iteration step for each operation
  always_comb begin
    mul_nxt  = acc_q + (b_q[0] ? mcand_q : '0);
    // Restoring step: shift {rem,dividend} left by one and try subtracting the divisor
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    div_ge   = ~div_diff[WIDTH];
    div_nxt  = {(div_ge ? div_diff[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction / accumulate / divide-by-zero override (FIX)
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_dz = 1'b0;
    prod   = neg_2w(acc_q, sa_q ^ sb_q);
    sum    = op_q[1] ? (base_q - prod) : (base_q + prod);
    if (is_div_q) begin
      if (b_q == '0) begin
        res_hi = base_q[WIDTH-1:0];
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = neg_w(acc_q[2*WIDTH-1:WIDTH], sa_q);
        res_lo = neg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
      end
    end else if (op_q[2]) begin
      {res_hi, res_lo} = sum;
    end else begin
      {res_hi, res_lo} = prod;
    end
  end

  // Next-state logic. CALC runs WIDTH iteration cycles (counter WIDTH..1)
  // plus one settle cycle at counter 0 before FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = CALC;
        cnt_d   = CNT_W'(WIDTH);
      end
      CALC: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
`ifdef MULDIV_EARLY_EXIT_EN
        // Remaining multiplier bits are zero: further steps only add zero
        else if (!is_div_q && cnt_q != CNT_W'(WIDTH) && b_q == '0) state_d = FIX;
`endif
      end
      FIX: begin
        state_d = DONE;
        hi_d    = res_hi;
        lo_d    = res_lo;
        dz_d    = res_dz;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers: only meaningful between accept and FIX, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      sa_q    <= in_sgn & srca[WIDTH-1];
      sb_q    <= in_sgn & srcb[WIDTH-1];
      b_q     <= b_mag;
      mcand_q <= {{WIDTH{1'b0}}, a_mag};
      if (in_div) begin
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
        base_q <= {{WIDTH{1'b0}}, srca};
      end else begin
        acc_q  <= '0;
        base_q <= {hi_in, lo_in};
      end
    end else if (state_q == CALC && cnt_q != '0) begin
      if (is_div_q) begin
        acc_q <= div_nxt;
      end else begin
        acc_q   <= mul_nxt;
        mcand_q <= mcand_q << 1;
        b_q     <= b_q >> 1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32 main instance, WIDTH=16 side instance).
module tb_muldiv_iter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    op = '0;
  logic [W-1:0]  srca = '0, srcb = '0, hi_in = '0, lo_in = '0;
  logic          cancel = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          div_zero;

  logic          v16 = 1'b0, rdy16, ov16, ordy16 = 1'b0, dz16;
  logic [2:0]    op16 = '0;
  logic [15:0]   a16 = '0, b16 = '0, hi16, lo16;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .srca(srca), .srcb(srcb), .hi_in(hi_in), .lo_in(lo_in), .cancel(cancel),
    .out_valid(out_valid), .out_ready(out_ready), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  muldiv_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .op(op16),
    .srca(a16), .srcb(b16), .hi_in(16'h0), .lo_in(16'h0), .cancel(1'b0),
    .out_valid(ov16), .out_ready(ordy16), .hi(hi16), .lo(lo16), .div_zero(dz16)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint      sa, sbv, q, r, p;
    logic [63:0] acc;
    sa  = (!o[0]) ? longint'($signed(a)) : longint'({32'b0, a});
    sbv = (!o[0]) ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[2] && o[1]) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      q = sa / sbv;
      r = sa % sbv;
      return {1'b0, r[31:0], q[31:0]};
    end
    p   = sa * sbv;
    acc = {h, l};
    if (o[2]) acc = o[1] ? (acc - p) : (acc + p);
    else      acc = p;
    return {1'b0, acc};
  endfunction

  // Drive one request, push its expectation, then scramble inputs after accept
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic [64:0] e);
    exp_t x;
    int   lat;
    lat = W + 2;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!(!o[2] && o[1])) begin
      logic [31:0] m;
      int          k;
      m = (!o[0] && b[31]) ? (32'd0 - b) : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      lat = k + 3;
    end
`endif
    x.dz  = e[64];
    x.hi  = e[63:32];
    x.lo  = e[31:0];
    x.lat = 8'(lat);
    sb_q.push_back(x);
    chk("in_ready before accept", in_ready, 1);
    op = o; srca = a; srcb = b; hi_in = h; lo_in = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    srca = $urandom; srcb = $urandom; hi_in = $urandom; lo_in = $urandom;
    op = 3'($urandom);
  endtask

  // Wait (bounded) for the result, compare, optionally hold out_ready low
  task automatic collect(input string tag, input int hold);
    exp_t x;
    int   lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb_q.pop_front();
    chk({tag, " latency"}, lat, x.lat);
    chk({tag, " hi"}, hi, x.hi);
    chk({tag, " lo"}, lo, x.lo);
    chk({tag, " div_zero"}, div_zero, x.dz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold hi/lo"}, {hi, lo}, {x.hi, x.lo});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " ready back"}, in_ready, 1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          seen, lat;

    // Reset state, checked before any clock edge
    #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset hi/lo", {hi, lo}, 64'h0);
    chk("reset div_zero", div_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    issue(3'b000, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
    collect("MULT -2*3", 5);
    issue(3'b011, 32'd100, 32'd7, 32'd0, 32'd0, {1'b0, 32'd2, 32'd14});
    collect("DIVU 100/7", 0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    collect("DIV -7/2", 0);
    issue(3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, {1'b0, 32'd1, 32'd0});
    collect("MADDU carry", 0);
    issue(3'b110, 32'd1, 32'd1, 32'd0, 32'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    collect("MSUB wrap", 0);
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          model(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    collect("MADDU max", 0);
    issue(3'b001, 32'd5, 32'd3, 32'd0, 32'd0, {1'b0, 32'd0, 32'd15});
    collect("MULTU 5*3", 0);
    issue(3'b010, 32'h1234, 32'd0, 32'd0, 32'd0, {1'b1, 32'h1234, 32'hFFFF_FFFF});
    collect("DIV by zero", 0);

    // Asynchronous reset in the middle of CALC, outputs checked before the next edge
    op = 3'b000; srca = 32'd7; srcb = 32'h7FFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst hi/lo", {hi, lo}, 64'h0);
    chk("midrst div_zero", div_zero, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, {1'b0, 32'd0, 32'h8000_0000});
    collect("DIV overflow", 0);

    // Cancel 10 cycles into a MULTU: unit idle next cycle, no result ever appears
    op = 3'b001; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    chk("cancel no result", seen, 0);

    // cancel together with in_valid in IDLE must not be accepted
    op = 3'b011; srca = 32'd9; srcb = 32'd3; in_valid = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    chk("cancel blocks accept", in_ready, 1);

    // Random operations through the reference model
    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom); ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      if (i == 1) rb = rb >> 20;
      issue(ro, ra, rb, rh, rl, model(ro, ra, rb, rh, rl));
      collect("random", 0);
    end

    // WIDTH=16 instance: MULTU 0xFFFF * 0xFFFF
    op16 = 3'b001; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16 latency", lat, 18);
    chk("w16 hi/lo", {hi16, lo16}, {16'hFFFE, 16'h0001});
    chk("w16 div_zero", dz16, 0);
    ordy16 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
    chk("w16 ready back", rdy16, 1);

    chk("scoreboard drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
